time_set_editor: RTL and testbench
==================================

# time_set_editor

Parametrised date/time setting editor for the clock front panel. It snapshots the live time when editing begins. The five panel buttons move a field cursor and step BCD fields, with press-edge detection and hold-to-auto-repeat. Calendar limits (month length, leap year) are enforced, the weekday is derived from the edited date, and the result is committed as a one-cycle load pulse to the timekeeping counter.

## Interface
- HOLD_CYCLES, 2500000, cycles a button must stay high after its press edge before auto-repeat starts (≥2)
- REPEAT_CYCLES, 500000, cycles between auto-repeat events while held (≥1)
- EDIT_MODE, 0, value of mode that enables editing
- YEAR_MIN, 2000, lowest settable year (decimal)
- YEAR_MAX, 2099, highest settable year (decimal)
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mode  in  4  panel mode select
- button_mid, button_l, button_r, button_up, button_down  in  1 each  clean, level-high buttons
- cur_year  in  16  live year, 4-digit BCD
- cur_month, cur_day, cur_hour, cur_minute, cur_sec  in  8 each  live values, 2-digit BCD
- year  out  16  edited year, BCD
- month, day, hour, minute, sec  out  8 each  edited values, BCD
- week  out  4  weekday of edited date, 0=Sunday..6=Saturday
- cursor  out  3  selected field: 0 year, 1 month, 2 day, 3 hour, 4 minute, 5 sec
- editing  out  1  high while in EDIT
- set_valid  out  1  one-cycle commit strobe; outputs hold the committed values during it

## Operation
- FSM states: IDLE and EDIT.
- IDLE: the field outputs copy the cur_* inputs every cycle. Cursor is held at 0.
- IDLE→EDIT: button_mid press event while mode==EDIT_MODE. The snapshot is the values already on the outputs; cursor is set to 0.
- EDIT: outputs change only through button events.
  - l: cursor−1, 0 wraps to 5.
  - r: cursor+1, 5 wraps to 0.
  - up/down: step the selected field ±1 with wrap.
    - year: YEAR_MIN..YEAR_MAX.
    - month: 1..12.
    - day: 1..days_in_month.
    - hour: 0..23.
    - minute, sec: 0..59.
- Leap year: divisible by 4 and not by 100, or divisible by 400.
- After any year or month change, day is clamped to that month's length (2024-03-31, month down → 2024-02-29).
- EDIT→IDLE (commit): button_mid event. set_valid=1 for exactly that one cycle; the next cycle is IDLE.
- EDIT→IDLE (abort): mode≠EDIT_MODE in any cycle. No set_valid; edits are discarded.
- Button events:
  - A press event fires on a cycle where the button is high and its registered previous sample was low.
  - While the button stays high, repeat events fire HOLD_CYCLES after the press event, then every REPEAT_CYCLES.
  - Only up/down auto-repeat; l, r and mid produce the press event only.
  - Releasing the button clears its hold counter.
- Simultaneous events: at most one action per cycle, priority mid > up > down > l > r. Lower-priority events in that cycle are dropped.
- week is combinational from the output fields:
  - Convert the fields to binary.
  - If m≤2: m+=12, y−=1.
  - week = (d + 2m + 3(m+1)/5 + y + y/4 − y/100 + y/400 + 1) mod 7, using integer division.
  - Internal arithmetic is at least 16 bits wide, with no negative intermediates.
- All BCD digits produced by the block are always valid (0–9).

## Timing
- Reset (rst_n=0 on a clock edge):
  - year=2023, month=1, day=1, hour=minute=sec=0, week=0, cursor=0.
  - editing=0, set_valid=0, state IDLE.
  - Button history and hold counters cleared.
- Reset overrides everything. Reset during EDIT discards edits with no set_valid.
- IDLE tracking: the outputs show cur_* one cycle late.
- Event latency: a press event sampled at edge k is visible on the outputs and cursor after edge k; editing is visible after the same edge.
- Repeat events of a continuously held button land at edges k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, and so on.
- The set_valid cycle and IDLE copying do not overlap: cur_* copying resumes on the cycle after set_valid.

## Test plan
- HOLD_CYCLES=4, REPEAT_CYCLES=2.
- Reset, then mode=0 and mid pulse with cur = 2024-02-28 10:00:00 → editing=1, week=3. Up on day → day=29, week=4. Up again → day=01.
- Edit 2023-03-31, month down → month=02, day=28. Repeat on 2000-03-31 → day=29. Repeat on 2100 (YEAR_MAX=2199) → day=28.
- Hold up continuously on minute=57 → minute changes at k (58), k+4 (59), k+6 (00), k+8 (01). Release resets the hold count.
- Cursor at 5, r → 0. Then l → 5. Pressing up and l in the same cycle → only the field increments; cursor stays.
- Edit hour to 23, press mid → set_valid high exactly one cycle with hour=0x23, then editing=0. Separate run: mode→1 mid-edit → no set_valid, outputs return to cur_*.
- Assert rst_n=0 during EDIT with year=2050 → next cycle year=0x2023, editing=0, cursor=0, set_valid=0.

Source files
------------

// File: rtl/time_set_editor.sv
// Date/time setting editor: snapshots the live time, steps BCD fields from the
// panel buttons with hold-to-repeat and calendar limits, and commits with a strobe.
module time_set_editor #(
   parameter int HOLD_CYCLES   = 2500000,
   parameter int REPEAT_CYCLES = 500000,
   parameter int EDIT_MODE     = 0,
   parameter int YEAR_MIN      = 2000,
   parameter int YEAR_MAX      = 2099
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  mode,
   input  logic        button_mid,
   input  logic        button_l,
   input  logic        button_r,
   input  logic        button_up,
   input  logic        button_down,
   input  logic [15:0] cur_year,
   input  logic [7:0]  cur_month,
   input  logic [7:0]  cur_day,
   input  logic [7:0]  cur_hour,
   input  logic [7:0]  cur_minute,
   input  logic [7:0]  cur_sec,
   output logic [15:0] year,
   output logic [7:0]  month,
   output logic [7:0]  day,
   output logic [7:0]  hour,
   output logic [7:0]  minute,
   output logic [7:0]  sec,
   output logic [3:0]  week,
   output logic [2:0]  cursor,
   output logic        editing,
   output logic        set_valid
);
   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [13:0] Y_MIN = 14'(YEAR_MIN);
   localparam logic [13:0] Y_MAX = 14'(YEAR_MAX);

   typedef enum logic {IDLE, EDIT} state_t;

   state_t                state_q, state_d;
   logic [15:0]           year_q, year_d;
   logic [7:0]            month_q, month_d, day_q, day_d, hour_q, hour_d;
   logic [7:0]            minute_q, minute_d, sec_q, sec_d;
   logic [2:0]            cursor_q, cursor_d;
   logic                  set_valid_q, set_valid_d;
   logic [4:0]            btn, btn_prev_q, btn_prev_d, evt;
   logic [1:0][CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]            rep_q, rep_d;
   logic [13:0]           yb, mb, db, hb, nb, sb, dim;
   logic [19:0]           wy, wm, wd, wsum;

   function automatic logic [6:0] bcd2_to_bin(input logic [7:0] b);
      return {3'd0, b[7:4]} * 7'd10 + {3'd0, b[3:0]};
   endfunction

   function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   function automatic logic [13:0] bcd4_to_bin(input logic [15:0] b);
      return {10'd0, b[15:12]} * 14'd1000 + {10'd0, b[11:8]} * 14'd100
           + {10'd0, b[7:4]} * 14'd10 + {10'd0, b[3:0]};
   endfunction

   function automatic logic [15:0] bin_to_bcd4(input logic [13:0] v);
      return {4'(v / 14'd1000), 4'((v / 14'd100) % 14'd10),
              4'((v / 14'd10) % 14'd10), 4'(v % 14'd10)};
   endfunction

   function automatic logic is_leap(input logic [13:0] y);
      return ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
   endfunction

   function automatic logic [13:0] days_in_month(input logic [13:0] y, input logic [13:0] m);
      case (m)
         14'd2:                        return is_leap(y) ? 14'd29 : 14'd28;
         14'd4, 14'd6, 14'd9, 14'd11:  return 14'd30;
         default:                      return 14'd31;
      endcase
   endfunction

   // Out-of-range values (e.g. an odd snapshot) wrap to the far end as well.
   function automatic logic [13:0] step(input logic [13:0] v, input logic [13:0] lo,
                                        input logic [13:0] hi, input logic up);
      if (up) return (v >= hi) ? lo : v + 14'd1;
      else    return (v <= lo) ? hi : v - 14'd1;
   endfunction

   assign btn        = {button_r, button_l, button_down, button_up, button_mid};
   assign btn_prev_d = btn;

   always_comb begin
      evt        = btn & ~btn_prev_q;
      hold_cnt_d = hold_cnt_q;
      rep_d      = rep_q;
      // Slot 0 tracks button_up, slot 1 tracks button_down.
      for (int i = 0; i < 2; i++) begin
         if (!btn[i+1]) begin
            hold_cnt_d[i] = '0;
            rep_d[i]      = 1'b0;
         end else if (!btn_prev_q[i+1]) begin
            hold_cnt_d[i] = CNT_W'(1);
            rep_d[i]      = 1'b0;
         end else if (!rep_q[i] && hold_cnt_q[i] == CNT_W'(HOLD_CYCLES)) begin
            evt[i+1]      = 1'b1;
            rep_d[i]      = 1'b1;
            hold_cnt_d[i] = CNT_W'(1);
         end else if (rep_q[i] && hold_cnt_q[i] == CNT_W'(REPEAT_CYCLES)) begin
            evt[i+1]      = 1'b1;
            hold_cnt_d[i] = CNT_W'(1);
         end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      year_d      = year_q;
      month_d     = month_q;
      day_d       = day_q;
      hour_d      = hour_q;
      minute_d    = minute_q;
      sec_d       = sec_q;
      cursor_d    = cursor_q;
      set_valid_d = 1'b0;
      yb  = bcd4_to_bin(year_q);
      mb  = {7'd0, bcd2_to_bin(month_q)};
      db  = {7'd0, bcd2_to_bin(day_q)};
      hb  = {7'd0, bcd2_to_bin(hour_q)};
      nb  = {7'd0, bcd2_to_bin(minute_q)};
      sb  = {7'd0, bcd2_to_bin(sec_q)};
      dim = days_in_month(yb, mb);
      if (state_q == IDLE && !(evt[0] && mode == 4'(EDIT_MODE))) begin
         year_d   = cur_year;
         month_d  = cur_month;
         day_d    = cur_day;
         hour_d   = cur_hour;
         minute_d = cur_minute;
         sec_d    = cur_sec;
         cursor_d = 3'd0;
      end else if (state_q == IDLE) begin
         state_d  = EDIT;
         cursor_d = 3'd0;
      end else if (mode != 4'(EDIT_MODE)) begin
         state_d  = IDLE;
         cursor_d = 3'd0;
         year_d   = cur_year;
         month_d  = cur_month;
         day_d    = cur_day;
         hour_d   = cur_hour;
         minute_d = cur_minute;
         sec_d    = cur_sec;
      end else if (evt[0]) begin
         state_d     = IDLE;
         cursor_d    = 3'd0;
         set_valid_d = 1'b1;
      end else if (evt[1] || evt[2]) begin
         case (cursor_q)
            3'd0:    yb = step(yb, Y_MIN, Y_MAX, evt[1]);
            3'd1:    mb = step(mb, 14'd1, 14'd12, evt[1]);
            3'd2:    db = step(db, 14'd1, dim, evt[1]);
            3'd3:    hb = step(hb, 14'd0, 14'd23, evt[1]);
            3'd4:    nb = step(nb, 14'd0, 14'd59, evt[1]);
            default: sb = step(sb, 14'd0, 14'd59, evt[1]);
         endcase
         dim = days_in_month(yb, mb);
         if (cursor_q <= 3'd1 && db > dim) db = dim;
         year_d   = bin_to_bcd4(yb);
         month_d  = bin_to_bcd2(7'(mb));
         day_d    = bin_to_bcd2(7'(db));
         hour_d   = bin_to_bcd2(7'(hb));
         minute_d = bin_to_bcd2(7'(nb));
         sec_d    = bin_to_bcd2(7'(sb));
      end else if (evt[3]) begin
         cursor_d = (cursor_q == 3'd0) ? 3'd5 : cursor_q - 3'd1;
      end else if (evt[4]) begin
         cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
      end
   end

   // Zeller-style weekday; January/February count as months 13/14 of the prior year.
   always_comb begin
      wy = {6'd0, bcd4_to_bin(year_q)};
      wm = {13'd0, bcd2_to_bin(month_q)};
      wd = {13'd0, bcd2_to_bin(day_q)};
      if (wm <= 20'd2) begin
         wm = wm + 20'd12;
         wy = wy - 20'd1;
      end
      wsum = wd + 20'd2 * wm + (20'd3 * (wm + 20'd1)) / 20'd5 + wy + wy / 20'd4
           - wy / 20'd100 + wy / 20'd400 + 20'd1;
      week = 4'(wsum % 20'd7);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         year_q      <= 16'h2023;
         month_q     <= 8'h01;
         day_q       <= 8'h01;
         hour_q      <= 8'h00;
         minute_q    <= 8'h00;
         sec_q       <= 8'h00;
         cursor_q    <= 3'd0;
         set_valid_q <= 1'b0;
         btn_prev_q  <= '0;
         hold_cnt_q  <= '0;
         rep_q       <= '0;
      end else begin
         state_q     <= state_d;
         year_q      <= year_d;
         month_q     <= month_d;
         day_q       <= day_d;
         hour_q      <= hour_d;
         minute_q    <= minute_d;
         sec_q       <= sec_d;
         cursor_q    <= cursor_d;
         set_valid_q <= set_valid_d;
         btn_prev_q  <= btn_prev_d;
         hold_cnt_q  <= hold_cnt_d;
         rep_q       <= rep_d;
      end
   end

   assign year      = year_q;
   assign month     = month_q;
   assign day       = day_q;
   assign hour      = hour_q;
   assign minute    = minute_q;
   assign sec       = sec_q;
   assign cursor    = cursor_q;
   assign editing   = (state_q == EDIT);
   assign set_valid = set_valid_q;
endmodule

// File: tb/tb_time_set_editor.sv
// Bench for time_set_editor: directed panel scenarios with literal expectations,
// then random button/mode/time traffic checked every cycle against a calendar model.
module tb_time_set_editor;
   localparam int HOLD = 4;
   localparam int REP  = 2;
   localparam int YMIN = 2000;
   localparam int YMAX = 2199;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  mode;
   logic [4:0]  btn;   // 0 mid, 1 up, 2 down, 3 l, 4 r
   logic [15:0] cur_year;
   logic [7:0]  cur_month, cur_day, cur_hour, cur_minute, cur_sec;
   logic [15:0] year;
   logic [7:0]  month, day, hour, minute, sec;
   logic [3:0]  week;
   logic [2:0]  cursor;
   logic        editing, set_valid;

   int checks = 0;
   int errors = 0;
   int c_y, c_mo, c_d, c_h, c_mi, c_s;
   int m_y, m_mo, m_d, m_h, m_mi, m_s, m_cur, m_ed, m_sv;
   int m_on = 0;
   int edge_n = 0;
   int m_prev[5];
   int m_press[5];

   time_set_editor #(
      .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .EDIT_MODE(0),
      .YEAR_MIN(YMIN), .YEAR_MAX(YMAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .button_mid(btn[0]), .button_l(btn[3]), .button_r(btn[4]),
      .button_up(btn[1]), .button_down(btn[2]),
      .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
      .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_sec(cur_sec),
      .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .sec(sec),
      .week(week), .cursor(cursor), .editing(editing), .set_valid(set_valid)
   );

   always #5 clk = ~clk;

   function automatic bit leap(input int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int dim(input int y, input int mo);
      int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      return len[mo-1] + ((mo == 2 && leap(y)) ? 1 : 0);
   endfunction

   // Count days from Saturday 2000-01-01.
   function automatic int weekday(input int y, input int mo, input int d);
      int n = d - 1;
      for (int yy = 2000; yy < y; yy++) n += leap(yy) ? 366 : 365;
      for (int mm = 1; mm < mo; mm++) n += dim(y, mm);
      return (n + 6) % 7;
   endfunction

   function automatic int bcd2(input int v);
      return (v / 10) * 16 + v % 10;
   endfunction

   function automatic int bcd4(input int v);
      return (v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
   endfunction

   function automatic int wrap(input int v, input int lo, input int hi);
      if (v > hi) return lo;
      if (v < lo) return hi;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_cur(input int y, input int mo, input int d, input int h,
                          input int mi, input int s);
      c_y = y; c_mo = mo; c_d = d; c_h = h; c_mi = mi; c_s = s;
      cur_year = 16'(bcd4(y));
      cur_month = 8'(bcd2(mo));
      cur_day = 8'(bcd2(d));
      cur_hour = 8'(bcd2(h));
      cur_minute = 8'(bcd2(mi));
      cur_sec = 8'(bcd2(s));
   endtask

   task automatic rand_cur();
      int y, mo;
      y = YMIN + int'($urandom_range(YMAX - YMIN));
      mo = 1 + int'($urandom_range(11));
      set_cur(y, mo, 1 + int'($urandom_range(dim(y, mo) - 1)), int'($urandom_range(23)),
              int'($urandom_range(59)), int'($urandom_range(59)));
   endtask

   task automatic copy_cur();
      m_y = c_y; m_mo = c_mo; m_d = c_d; m_h = c_h; m_mi = c_mi; m_s = c_s;
   endtask

   task automatic bump(input int dir);
      case (m_cur)
         0: m_y = wrap(m_y + dir, YMIN, YMAX);
         1: m_mo = wrap(m_mo + dir, 1, 12);
         2: m_d = wrap(m_d + dir, 1, dim(m_y, m_mo));
         3: m_h = wrap(m_h + dir, 0, 23);
         4: m_mi = wrap(m_mi + dir, 0, 59);
         default: m_s = wrap(m_s + dir, 0, 59);
      endcase
      if (m_d > dim(m_y, m_mo)) m_d = dim(m_y, m_mo);
   endtask

   task automatic model_step();
      int ev[5];
      int e;
      if (!rst_n) begin
         m_on = 1;
         m_y = 2023; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0;
         m_cur = 0; m_ed = 0; m_sv = 0;
         for (int i = 0; i < 5; i++) m_prev[i] = 0;
      end else if (m_on != 0) begin
         for (int i = 0; i < 5; i++) begin
            ev[i] = 0;
            if (btn[i]) begin
               if (m_prev[i] == 0) begin
                  ev[i] = 1;
                  m_press[i] = edge_n;
               end else if (i == 1 || i == 2) begin
                  e = edge_n - m_press[i];
                  if (e == HOLD || (e > HOLD && (e - HOLD) % REP == 0)) ev[i] = 1;
               end
            end
            m_prev[i] = int'(btn[i]);
         end
         m_sv = 0;
         if (m_ed == 0) begin
            if (ev[0] != 0 && mode == 4'd0) begin m_ed = 1; m_cur = 0; end
            else copy_cur();
         end else if (mode != 4'd0) begin
            m_ed = 0; m_cur = 0; copy_cur();
         end else if (ev[0] != 0) begin
            m_ed = 0; m_sv = 1; m_cur = 0;
         end else if (ev[1] != 0) bump(1);
         else if (ev[2] != 0) bump(-1);
         else if (ev[3] != 0) m_cur = (m_cur + 5) % 6;
         else if (ev[4] != 0) m_cur = (m_cur + 1) % 6;
      end
      edge_n++;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_on != 0) begin
         chk("year", int'(year), bcd4(m_y));
         chk("month", int'(month), bcd2(m_mo));
         chk("day", int'(day), bcd2(m_d));
         chk("hour", int'(hour), bcd2(m_h));
         chk("minute", int'(minute), bcd2(m_mi));
         chk("sec", int'(sec), bcd2(m_s));
         chk("week", int'(week), weekday(m_y, m_mo, m_d));
         chk("cursor", int'(cursor), m_cur);
         chk("editing", int'(editing), m_ed);
         chk("set_valid", int'(set_valid), m_sv);
      end
   end

   task automatic pulse(input int b);
      btn[b] = 1'b1;
      @(negedge clk);
      btn[b] = 1'b0;
      @(negedge clk);
   endtask

   task automatic abort_to(input int y, input int mo, input int d, input int h,
                           input int mi, input int s);
      mode = 4'd1;
      set_cur(y, mo, d, h, mi, s);
      @(negedge clk);
      chk("abort_editing", int'(editing), 0);
      chk("abort_year", int'(year), bcd4(y));
      mode = 4'd0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      mode = 4'd0;
      btn = '0;
      set_cur(2024, 2, 28, 10, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_year", int'(year), 'h2023);
      chk("rst_month", int'(month), 'h01);
      chk("rst_day", int'(day), 'h01);
      chk("rst_week", int'(week), 0);
      chk("rst_cursor", int'(cursor), 0);
      chk("rst_editing", int'(editing), 0);
      chk("rst_set_valid", int'(set_valid), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_track", int'(year), 'h2024);
      pulse(0);
      chk("enter_editing", int'(editing), 1);
      chk("enter_week", int'(week), 3);
      pulse(4); pulse(4); pulse(1);
      chk("leap_day29", int'(day), 'h29);
      chk("leap_week", int'(week), 4);
      pulse(1);
      chk("day_wrap", int'(day), 'h01);

      abort_to(2023, 3, 31, 0, 0, 0);
      pulse(0); pulse(4); pulse(2);
      chk("clamp_month", int'(month), 'h02);
      chk("clamp_day", int'(day), 'h28);
      abort_to(2000, 3, 31, 0, 0, 0);
      pulse(0); pulse(4); pulse(2);
      chk("clamp_2000", int'(day), 'h29);
      abort_to(2100, 3, 31, 0, 0, 0);
      pulse(0); pulse(4); pulse(2);
      chk("clamp_2100", int'(day), 'h28);

      abort_to(2024, 1, 1, 0, 57, 0);
      pulse(0);
      repeat (4) pulse(4);
      btn[1] = 1'b1;
      @(negedge clk);
      chk("hold_k", int'(minute), 'h58);
      repeat (3) @(negedge clk);
      chk("hold_k3", int'(minute), 'h58);
      @(negedge clk);
      chk("hold_k4", int'(minute), 'h59);
      repeat (2) @(negedge clk);
      chk("hold_k6", int'(minute), 'h00);
      repeat (2) @(negedge clk);
      chk("hold_k8", int'(minute), 'h01);
      btn[1] = 1'b0;
      @(negedge clk);
      btn[1] = 1'b1;
      @(negedge clk);
      chk("repress", int'(minute), 'h02);
      repeat (3) @(negedge clk);
      chk("repress_k3", int'(minute), 'h02);
      @(negedge clk);
      chk("repress_k4", int'(minute), 'h03);
      btn[1] = 1'b0;
      @(negedge clk);

      pulse(4); pulse(4);
      chk("cursor_r_wrap", int'(cursor), 0);
      pulse(3);
      chk("cursor_l_wrap", int'(cursor), 5);
      btn[1] = 1'b1; btn[3] = 1'b1;
      @(negedge clk);
      btn[1] = 1'b0; btn[3] = 1'b0;
      @(negedge clk);
      chk("prio_sec", int'(sec), 'h01);
      chk("prio_cursor", int'(cursor), 5);

      pulse(3); pulse(3); pulse(2);
      chk("hour_wrap", int'(hour), 'h23);
      btn[0] = 1'b1;
      @(negedge clk);
      chk("commit_sv", int'(set_valid), 1);
      chk("commit_hour", int'(hour), 'h23);
      btn[0] = 1'b0;
      @(negedge clk);
      chk("commit_sv_off", int'(set_valid), 0);
      chk("commit_editing", int'(editing), 0);
      chk("copy_resume", int'(hour), 'h00);

      set_cur(2050, 6, 15, 12, 30, 45);
      @(negedge clk);
      pulse(0); pulse(4);
      chk("pre_rst_year", int'(year), 'h2050);
      rst_n = 1'b0;
      @(negedge clk);
      chk("edit_rst_year", int'(year), 'h2023);
      chk("edit_rst_editing", int'(editing), 0);
      chk("edit_rst_cursor", int'(cursor), 0);
      chk("edit_rst_sv", int'(set_valid), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(399) != 0);
         if (mode != 4'd0) begin
            if ($urandom_range(3) == 0) mode = 4'd0;
         end else if ($urandom_range(39) == 0) begin
            mode = 4'($urandom_range(15));
         end
         if ($urandom_range(19) == 0) btn[0] = ~btn[0];
         if ($urandom_range(7) == 0) btn[1] = ~btn[1];
         if ($urandom_range(7) == 0) btn[2] = ~btn[2];
         if ($urandom_range(5) == 0) btn[3] = ~btn[3];
         if ($urandom_range(5) == 0) btn[4] = ~btn[4];
         if ($urandom_range(9) == 0) rand_cur();
         @(negedge clk);
      end
      rst_n = 1'b1;
      btn = '0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
